alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle execute-stage ALU.
- Covers the full RV32I integer op set, including correct arithmetic shift right and SLT/SLTU.
- Produces zero/negative/carry/overflow flags for every op and an illegal-op indication.
- Shifts run iteratively, SHIFT_STEP bits per cycle, to keep the barrel shifter off the critical path.
- Sits between decode/operand-forward and the EX/MEM register; the pipeline stalls on in_ready / out_valid.

Parameters:
- WIDTH, 32: operand/result width; power of 2, >= 8.
- SHIFT_STEP, 4: max bits shifted per cycle; power of 2, 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept an op
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B; for shifts only B[log2(WIDTH)-1:0] is used as shamt
- ALUcontrol  input  4  operation select
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zeroflag  output  1  result == 0
- negflag  output  1  result[WIDTH-1]
- carryflag  output  1  ADD: carry-out; SUB: carry-out of A+~B+1 (1 when A >= B unsigned); 0 otherwise
- ovflag  output  1  signed overflow for ADD/SUB; 0 otherwise
- illegal  output  1  ALUcontrol not in the encoding list

Behaviour:
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU; SLT/SLTU result is 1 or 0, zero-extended.
  - Any other code: result 0, illegal=1, zeroflag=1, all other flags 0.
- Reset:
  - Applies on a clk edge with rst_n=0. State -> IDLE.
  - out_valid, result, all flags and illegal -> 0.
  - in_ready is 0 while rst_n=0.
  - Reset mid-operation abandons the op; no output is produced.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE) && rst_n.
  - out_valid = (state==DONE).
- Accept on an edge with in_valid && in_ready; A, B and ALUcontrol are captured at that edge.
- Non-shift op, or shift with shamt=0:
  - Compute at the accept edge, go to DONE.
  - out_valid high the next cycle; latency 1.
- Shift with shamt k>0:
  - Accept edge: load acc=A, rem=k, state SHIFT.
  - Each SHIFT edge: shift acc by s=min(SHIFT_STEP, rem), rem -= s.
  - SLL fills zeros; SRL fills zeros; SRA fills copies of A[WIDTH-1].
  - When rem reaches 0, result=acc and flags are written; state DONE.
  - Latency = 1 + ceil(k/SHIFT_STEP) cycles.
- DONE:
  - result, flags and illegal are held stable while out_ready=0.
  - On an edge with out_ready=1: state IDLE, out_valid 0.
  - result/flags keep their last value after handoff; they are don't-care when out_valid=0.
- Throughput: max one op per 2 cycles; no accept in DONE, even when out_ready=1.
- Flags: zeroflag and negflag are computed from the final result for all legal ops, including shifts.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH.
  - carry is computed on WIDTH+1 bits.
  - ovflag = (A[msb]==B'[msb]) && (result[msb]!=A[msb]), where B' = B for ADD and ~B for SUB.
- Inputs are ignored when not accepted.
- in_valid may drop without being accepted; no state change results.

Test Plan (WIDTH=32, SHIFT_STEP=4):
1. ADD A=0xFFFFFFFF, B=1 -> one cycle after accept: out_valid=1, result=0, zeroflag=1, carryflag=1, ovflag=0, negflag=0.
2. SUB A=0x80000000, B=1 -> result 0x7FFFFFFF, ovflag=1, carryflag=1, negflag=0; SUB A=5, B=5 -> result 0, zeroflag=1, carryflag=1.
3. SRA A=0x80000000:
   - B=0x23 (shamt 3) -> result 0xF0000000, out_valid 2 cycles after accept.
   - B=31 -> result 0xFFFFFFFF, 9 cycles after accept.
   - SRL with A=0x80000000, B=31 -> result 1.
   - SLL with A=1, B=0 -> result 1, latency 1.
4. SLT A=0xFFFFFFFF, B=1 -> result 1; SLTU with the same operands -> result 0, zeroflag=1.
5. Backpressure: ADD 3+4 with out_ready=0 for 5 cycles.
   - result=7 and out_valid are held stable; in_ready=0 throughout.
   - After out_ready=1 for one edge: in_ready=1 next cycle, and a new op is accepted.
6. Illegal op and reset:
   - ALUcontrol=1111 -> result 0, illegal=1.
   - rst_n=0 for one edge during SHIFT of a shamt=31 op -> next cycle out_valid=0, in_ready=1 after rst_n returns high; the abandoned result is never presented.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the operand-forward stage, the ALU and the EX/MEM register.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUcontrol;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zeroflag;
    logic             negflag;
    logic             carryflag;
    logic             ovflag;
    logic             illegal;

    modport master (
        output in_valid, A, B, ALUcontrol, out_ready,
        input  in_ready, out_valid, result, zeroflag, negflag, carryflag, ovflag, illegal
    );

    modport slave (
        input  in_valid, A, B, ALUcontrol, out_ready,
        output in_ready, out_valid, result, zeroflag, negflag, carryflag, ovflag, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked RV32I-style ALU. Logic ops and add/sub/compare finish in one cycle;
// shifts walk SHIFT_STEP bits per cycle so no full barrel shifter sits in the path.
//
// state | meaning
// IDLE  | waiting for an op, in_ready high
// SHIFT | iterative shift in progress, rem_q bits still to go
// DONE  | result/flags presented, waiting for out_ready
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zeroflag_q, zeroflag_d;
    logic             negflag_q, negflag_d;
    logic             carryflag_q, carryflag_d;
    logic             ovflag_q, ovflag_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH:0]   sum_w, dif_w;
    logic [WIDTH-1:0] imm_res;
    logic             imm_cf, imm_of, imm_ill;
    logic [SW-1:0]    shamt;
    logic             is_shift;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] acc_sh;

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zeroflag  = zeroflag_q;
    assign bus.negflag   = negflag_q;
    assign bus.carryflag = carryflag_q;
    assign bus.ovflag    = ovflag_q;
    assign bus.illegal   = illegal_q;

    assign shamt    = bus.B[SW-1:0];
    assign is_shift = (bus.ALUcontrol == OP_SLL) || (bus.ALUcontrol == OP_SRL) ||
                      (bus.ALUcontrol == OP_SRA);

    // Single-cycle result and flags for the op currently on the input bus.
    always_comb begin
        imm_res = '0;
        imm_cf  = 1'b0;
        imm_of  = 1'b0;
        imm_ill = 1'b0;
        sum_w   = {1'b0, bus.A} + {1'b0, bus.B};
        dif_w   = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
        case (bus.ALUcontrol)
            OP_AND: imm_res = bus.A & bus.B;
            OP_OR:  imm_res = bus.A | bus.B;
            OP_XOR: imm_res = bus.A ^ bus.B;
            OP_ADD: begin
                imm_res = sum_w[WIDTH-1:0];
                imm_cf  = sum_w[WIDTH];
                imm_of  = (bus.A[MSB] == bus.B[MSB]) && (sum_w[MSB] != bus.A[MSB]);
            end
            OP_SUB: begin
                imm_res = dif_w[WIDTH-1:0];
                imm_cf  = dif_w[WIDTH];
                imm_of  = (bus.A[MSB] != bus.B[MSB]) && (dif_w[MSB] != bus.A[MSB]);
            end
            // Zero-distance shifts bypass the iterative path.
            OP_SLL, OP_SRL, OP_SRA: imm_res = bus.A;
            OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            default: imm_ill = 1'b1;
        endcase
    end

    // One iteration of the shifter: at most SHIFT_STEP bits, never past the remaining distance.
    always_comb begin
        step = SW'(SHIFT_STEP);
        if (32'(rem_q) < 32'(SHIFT_STEP)) begin
            step = rem_q;
        end
        case (op_q)
            OP_SLL:  acc_sh = acc_q << step;
            OP_SRL:  acc_sh = acc_q >> step;
            OP_SRA:  acc_sh = $signed(acc_q) >>> step;
            default: acc_sh = acc_q;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        op_d        = op_q;
        result_d    = result_q;
        zeroflag_d  = zeroflag_q;
        negflag_d   = negflag_q;
        carryflag_d = carryflag_q;
        ovflag_d    = ovflag_q;
        illegal_d   = illegal_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = bus.A;
                        rem_d   = shamt;
                        op_d    = bus.ALUcontrol;
                        state_d = SHIFT;
                    end else begin
                        result_d    = imm_res;
                        zeroflag_d  = (imm_res == '0);
                        negflag_d   = imm_res[MSB];
                        carryflag_d = imm_cf;
                        ovflag_d    = imm_of;
                        illegal_d   = imm_ill;
                        state_d     = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_sh;
                rem_d = rem_q - step;
                if (rem_q == step) begin
                    result_d    = acc_sh;
                    zeroflag_d  = (acc_sh == '0);
                    negflag_d   = acc_sh[MSB];
                    carryflag_d = 1'b0;
                    ovflag_d    = 1'b0;
                    illegal_d   = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            result_q    <= '0;
            zeroflag_q  <= 1'b0;
            negflag_q   <= 1'b0;
            carryflag_q <= 1'b0;
            ovflag_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            result_q    <= result_d;
            zeroflag_q  <= zeroflag_d;
            negflag_q   <= negflag_d;
            carryflag_q <= carryflag_d;
            ovflag_q    <= ovflag_d;
            illegal_q   <= illegal_d;
        end
    end
endmodule
